// File: rtl/lsu_axi_rd_arb_pkg.sv
// Shared types and field widths for the LSU AXI read arbiter.
// The FSM state encoding, the command field widths and the packed
// per-command struct live here so that every file agrees on them.
package lsu_axi_rd_arb_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int STR_W   = 3;
  localparam int SRAM_W  = 12;
  localparam int NUM_W   = 8;
  localparam int DATA_W  = 64;
  localparam int RESP_W  = 2;
  localparam int WDOG_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // The DRAM address is parameterised, so it is carried next to this
  // struct rather than inside it.
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [STR_W-1:0]   str;
    logic [SRAM_W-1:0]  sram_addr;
    logic [NUM_W-1:0]   num;
  } lsu_rd_cmd_t;

  // Width of an index into n requesters, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsu_axi_rd_arb_if.sv
// Bundle of the requester-side and downstream-side signals of the
// LSU AXI read arbiter. The slave modport is the arbiter's view, the
// master modport is the view of whatever surrounds it.
interface lsu_axi_rd_arb_if
  import lsu_axi_rd_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 10
) ();

  logic [NREQ-1:0]         req_arvld;
  logic [NREQ*ADDR_W-1:0]  req_araddr;
  logic [NREQ*LEN_W-1:0]   req_arlen;
  logic [NREQ*SIZE_W-1:0]  req_arsize;
  logic [NREQ*BURST_W-1:0] req_arburst;
  logic [NREQ*STR_W-1:0]   req_arstr;
  logic [NREQ*SRAM_W-1:0]  req_sram_addr;
  logic [NREQ*NUM_W-1:0]   req_arnum;
  logic [NREQ-1:0]         req_arrdy;
  logic [NREQ-1:0]         req_rrdy;
  logic [NREQ-1:0]         req_rvld;
  logic [DATA_W-1:0]       req_rdata;
  logic [RESP_W-1:0]       req_rresp;
  logic                    req_rlast;
  logic [SRAM_W-1:0]       req_sram_addr_o;
  logic [NREQ-1:0]         req_done;

  logic [ADDR_W-1:0]       arb_araddr;
  logic [LEN_W-1:0]        arb_arlen;
  logic [SIZE_W-1:0]       arb_arsize;
  logic [BURST_W-1:0]      arb_arburst;
  logic [STR_W-1:0]        arb_arstr;
  logic [SRAM_W-1:0]       arb_sram_addr;
  logic [NUM_W-1:0]        arb_arnum;
  logic                    arb_arvld;
  logic                    arb_rrdy;

  logic                    axi_arrdy;
  logic                    axi_rvld;
  logic [DATA_W-1:0]       axi_rdata;
  logic [RESP_W-1:0]       axi_rresp;
  logic                    axi_rlast;
  logic [SRAM_W-1:0]       axi_sram_addr;
  logic                    axi_done;

  logic                    wdog_err;

  modport slave (
    input  req_arvld, req_araddr, req_arlen, req_arsize, req_arburst,
           req_arstr, req_sram_addr, req_arnum, req_rrdy,
           axi_arrdy, axi_rvld, axi_rdata, axi_rresp, axi_rlast,
           axi_sram_addr, axi_done,
    output req_arrdy, req_rvld, req_rdata, req_rresp, req_rlast,
           req_sram_addr_o, req_done,
           arb_araddr, arb_arlen, arb_arsize, arb_arburst, arb_arstr,
           arb_sram_addr, arb_arnum, arb_arvld, arb_rrdy, wdog_err
  );

  modport master (
    output req_arvld, req_araddr, req_arlen, req_arsize, req_arburst,
           req_arstr, req_sram_addr, req_arnum, req_rrdy,
           axi_arrdy, axi_rvld, axi_rdata, axi_rresp, axi_rlast,
           axi_sram_addr, axi_done,
    input  req_arrdy, req_rvld, req_rdata, req_rresp, req_rlast,
           req_sram_addr_o, req_done,
           arb_araddr, arb_arlen, arb_arsize, arb_arburst, arb_arstr,
           arb_sram_addr, arb_arnum, arb_arvld, arb_rrdy, wdog_err
  );

endinterface

// File: rtl/lsu_axi_rd_arb_rr_arb.sv
// Round-robin picker: starting at ptr and searching upward with
// wrap-around, returns the first active request as a one-hot grant
// plus its index. vld is low when nobody is requesting.
module rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  // Walk the requesters in priority order and keep only the first hit.
  always_comb begin
    int cand;
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lsu_axi_rd_arb.sv
// LSU AXI read arbiter: grants one of NREQ load requesters at a time,
// forwards its command downstream, steers the read responses back to
// it and pulses req_done once the downstream engine has finished.
// Build option: define LSU_AXI_RD_ARB_WDOG_EN to add the stall
// watchdog driving wdog_err; otherwise wdog_err is tied low.
module lsu_axi_rd_arb
  import lsu_axi_rd_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 10,
  parameter int WDOG_CYC = 1024
) (
  input logic              clk,
  input logic              rst,
  lsu_axi_rd_arb_if.slave  bus
);

  localparam int PTR_W = ptr_width(NREQ);

  arb_state_t        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic              busy_first;
  logic              arvld_q;
  logic [ADDR_W-1:0] cmd_addr;
  lsu_rd_cmd_t       cmd;

  logic [NREQ-1:0]   gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic [ADDR_W-1:0] win_addr;
  lsu_rd_cmd_t       win_cmd;
  logic [NREQ-1:0]   owner_oh;
  logic              grant;
  logic              resp_phase;
  logic              drain_exit;

  rr_arb #(.N(NREQ), .PTR_W(PTR_W)) u_rr_arb (
    .req (bus.req_arvld),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .vld (gnt_vld)
  );

  // Everything visible is held low while rst is asserted, even before
  // the reset edge has pulled the FSM back to IDLE.
  assign grant      = (state == IDLE) && gnt_vld && bus.axi_arrdy && !rst;
  assign resp_phase = ((state == BUSY) || (state == DRAIN)) && !rst;
  assign drain_exit = (state == DRAIN) && !bus.axi_rvld && !rst;

  // Pick the winning requester's command fields out of the packed inputs.
  always_comb begin
    win_addr          = bus.req_araddr[gnt_idx*ADDR_W +: ADDR_W];
    win_cmd.len       = bus.req_arlen[gnt_idx*LEN_W +: LEN_W];
    win_cmd.size      = bus.req_arsize[gnt_idx*SIZE_W +: SIZE_W];
    win_cmd.burst     = bus.req_arburst[gnt_idx*BURST_W +: BURST_W];
    win_cmd.str       = bus.req_arstr[gnt_idx*STR_W +: STR_W];
    win_cmd.sram_addr = bus.req_sram_addr[gnt_idx*SRAM_W +: SRAM_W];
    win_cmd.num       = bus.req_arnum[gnt_idx*NUM_W +: NUM_W];
  end

  // One-hot view of the current owner for steering rvld and done.
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // Transaction FSM: grant, issue, collect responses, drain, rotate.
  // axi_done is ignored in the first BUSY cycle because the downstream
  // done counter only catches up one cycle after the command is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      busy_first <= 1'b0;
      arvld_q    <= 1'b0;
      cmd_addr   <= '0;
      cmd        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner    <= gnt_idx;
            cmd_addr <= win_addr;
            cmd      <= win_cmd;
            arvld_q  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (arvld_q && bus.axi_arrdy) begin
            arvld_q    <= 1'b0;
            busy_first <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          busy_first <= 1'b0;
          if (!busy_first && bus.axi_done) state <= DRAIN;
        end
        DRAIN: begin
          if (!bus.axi_rvld) begin
            state  <= IDLE;
            rr_ptr <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_arrdy       = grant ? gnt : '0;
  assign bus.arb_arvld       = arvld_q && !rst;
  assign bus.arb_araddr      = cmd_addr;
  assign bus.arb_arlen       = cmd.len;
  assign bus.arb_arsize      = cmd.size;
  assign bus.arb_arburst     = cmd.burst;
  assign bus.arb_arstr       = cmd.str;
  assign bus.arb_sram_addr   = cmd.sram_addr;
  assign bus.arb_arnum       = cmd.num;

  assign bus.req_rvld        = (resp_phase && bus.axi_rvld) ? owner_oh : '0;
  assign bus.arb_rrdy        = resp_phase && bus.req_rrdy[owner];
  assign bus.req_rdata       = bus.axi_rdata;
  assign bus.req_rresp       = bus.axi_rresp;
  assign bus.req_rlast       = bus.axi_rlast;
  assign bus.req_sram_addr_o = bus.axi_sram_addr;
  assign bus.req_done        = drain_exit ? owner_oh : '0;

`ifdef LSU_AXI_RD_ARB_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_err_q;

  // Stall watchdog: counts cycles without response progress while a
  // command is pending and latches a sticky error once the limit is hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (grant || (bus.axi_rvld && bus.arb_rrdy)) begin
        wdog_cnt <= '0;
      end else if (((state == ISSUE) || (state == BUSY)) && (wdog_cnt != '1)) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (int'(wdog_cnt) >= WDOG_CYC) wdog_err_q <= 1'b1;
    end
  end

  assign bus.wdog_err = wdog_err_q && !rst;
`else
  assign bus.wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_axi_rd_arb.sv
// Directed bench for lsu_axi_rd_arb: expected grants and completions
// are queued as stimulus is driven and popped when the DUT pulses
// req_arrdy / req_done; per-cycle expectations are checked inline.
module tb_lsu_axi_rd_arb;
  import lsu_axi_rd_arb_pkg::*;

  localparam int NREQ     = 4;
  localparam int ADDR_W   = 10;
  localparam int WDOG_CYC = 16;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;
  int exp_grant_q[$];
  int exp_done_q[$];
  bit grant_open = 1'b0;

  always #5 clk = ~clk;

  lsu_axi_rd_arb_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

  lsu_axi_rd_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WDOG_CYC(WDOG_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: match every grant / done pulse against the queues.
  task automatic monitor();
    int e;
    if (bus.req_arrdy != '0) begin
      if (exp_grant_q.size() == 0) begin
        checkOutput("spurious_grant", 64'(bus.req_arrdy), 64'd0);
      end else begin
        e = exp_grant_q.pop_front();
        checkOutput("grant_onehot", 64'(bus.req_arrdy), 64'd1 << e);
      end
      checkOutput("grant_while_busy", 64'(grant_open), 64'd0);
      grant_open = 1'b1;
    end
    if (bus.req_done != '0) begin
      if (exp_done_q.size() == 0) begin
        checkOutput("spurious_done", 64'(bus.req_done), 64'd0);
      end else begin
        e = exp_done_q.pop_front();
        checkOutput("done_onehot", 64'(bus.req_done), 64'd1 << e);
      end
      grant_open = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic arrdy, input logic rvld, input logic done,
                               input logic [NREQ-1:0] rrdy, input logic [63:0] data);
    bus.axi_arrdy     = arrdy;
    bus.axi_rvld      = rvld;
    bus.axi_done      = done;
    bus.req_rrdy      = rrdy;
    bus.axi_rdata     = data;
    bus.axi_rresp     = data[1:0];
    bus.axi_rlast     = rvld;
    bus.axi_sram_addr = data[11:0];
    #1;
    monitor();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int idx, input logic [ADDR_W-1:0] addr,
                        input logic [7:0] num, input logic [11:0] sram);
    bus.req_araddr[idx*ADDR_W +: ADDR_W] = addr;
    bus.req_arnum[idx*8 +: 8]            = num;
    bus.req_arlen[idx*8 +: 8]            = 8'(idx + 1);
    bus.req_arsize[idx*3 +: 3]           = 3'd3;
    bus.req_arburst[idx*2 +: 2]          = 2'd1;
    bus.req_arstr[idx*3 +: 3]            = 3'(idx);
    bus.req_sram_addr[idx*12 +: 12]      = sram;
  endtask

  // Minimal-latency transaction: grant, issue, one beat, done, drain.
  task automatic runTxn(input int owner, input logic [ADDR_W-1:0] addr,
                        input logic [7:0] num, input logic [63:0] data);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("issue_arvld", 64'(bus.arb_arvld), 64'd1);
    checkOutput("issue_araddr", 64'(bus.arb_araddr), 64'(addr));
    checkOutput("issue_arnum", 64'(bus.arb_arnum), 64'(num));
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, data);
    checkOutput("busy_arvld", 64'(bus.arb_arvld), 64'd0);
    checkOutput("busy_rvld", 64'(bus.req_rvld), 64'd1 << owner);
    checkOutput("busy_rdata", bus.req_rdata, data);
    checkOutput("busy_rrdy", 64'(bus.arb_rrdy), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 64'd0);
    checkOutput("busy_no_done", 64'(bus.req_done), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("drain_done", 64'(bus.req_done), 64'd1 << owner);
    nextCycle();
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_arvld = '0;
    for (int i = 0; i < NREQ; i++) setReq(i, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 64'd0);
    nextCycle();

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("rst_arvld", 64'(bus.arb_arvld), 64'd0);
    checkOutput("rst_arrdy", 64'(bus.req_arrdy), 64'd0);
    checkOutput("rst_rvld", 64'(bus.req_rvld), 64'd0);
    checkOutput("rst_done", 64'(bus.req_done), 64'd0);
    checkOutput("rst_rrdy", 64'(bus.arb_rrdy), 64'd0);
    checkOutput("rst_wdog", 64'(bus.wdog_err), 64'd0);
    checkOutput("rst_araddr", 64'(bus.arb_araddr), 64'd0);
    nextCycle();
    rst = 1'b0;

    // Single request from requester 1, stale axi_done in first BUSY cycle
    $display("[TB] single request");
    setReq(1, 10'h040, 8'd2, 12'h123);
    bus.req_arvld = 4'b0010;
    exp_grant_q.push_back(1);
    exp_done_q.push_back(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("a_arvld_idle", 64'(bus.arb_arvld), 64'd0);
    nextCycle();
    bus.req_arvld = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("a_arvld", 64'(bus.arb_arvld), 64'd1);
    checkOutput("a_araddr", 64'(bus.arb_araddr), 64'h040);
    checkOutput("a_arnum", 64'(bus.arb_arnum), 64'd2);
    checkOutput("a_arlen", 64'(bus.arb_arlen), 64'd2);
    checkOutput("a_sram", 64'(bus.arb_sram_addr), 64'h123);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0010, 64'hCAFE_0000_0000_0A51);
    checkOutput("a_arvld_off", 64'(bus.arb_arvld), 64'd0);
    checkOutput("a_rvld", 64'(bus.req_rvld), 64'b0010);
    checkOutput("a_rrdy", 64'(bus.arb_rrdy), 64'd1);
    checkOutput("a_rdata", bus.req_rdata, 64'hCAFE_0000_0000_0A51);
    checkOutput("a_sram_o", 64'(bus.req_sram_addr_o), 64'hA51);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0010, 64'h1234);
    checkOutput("a_rvld2", 64'(bus.req_rvld), 64'b0010);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010, 64'd0);
    checkOutput("a_done_ignored", 64'(bus.req_done), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0010, 64'd0);
    checkOutput("a_done_early", 64'(bus.req_done), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010, 64'd0);
    checkOutput("a_done", 64'(bus.req_done), 64'b0010);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 64'd0);
    checkOutput("a_idle_rvld", 64'(bus.req_rvld), 64'd0);
    checkOutput("a_idle_rrdy", 64'(bus.arb_rrdy), 64'd0);
    nextCycle();

    // All requesters asserting from reset: order 0,1,2,3,0
    $display("[TB] round robin");
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) setReq(i, 10'(10'h100 + i*16), 8'(i + 3), 12'(i));
    bus.req_arvld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_grant_q.push_back(k % 4);
      exp_done_q.push_back(k % 4);
    end
    for (int k = 0; k < 5; k++)
      runTxn(k % 4, 10'(10'h100 + (k % 4)*16), 8'((k % 4) + 3), 64'hDEAD_0000 + 64'(k));
    bus.req_arvld = '0;

    // Requester 2 owns responses but stalls req_rrdy for 3 cycles
    $display("[TB] response backpressure");
    setReq(2, 10'h2A0, 8'd4, 12'h2A0);
    bus.req_arvld = 4'b0100;
    exp_grant_q.push_back(2);
    exp_done_q.push_back(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    bus.req_arvld = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b1011, 64'h77);
      checkOutput("c_rrdy_low", 64'(bus.arb_rrdy), 64'd0);
      checkOutput("c_rvld_held", 64'(bus.req_rvld), 64'b0100);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 64'h77);
    checkOutput("c_rrdy_high", 64'(bus.arb_rrdy), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("c_done", 64'(bus.req_done), 64'b0100);
    nextCycle();

    // axi_arrdy low for 5 ISSUE cycles, zero-length command
    $display("[TB] issue stall");
    setReq(3, 10'h3FF, 8'd0, 12'hFFF);
    bus.req_arvld = 4'b1000;
    exp_grant_q.push_back(3);
    exp_done_q.push_back(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    bus.req_arvld = '0;
    setReq(3, 10'h055, 8'hAA, 12'h000);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, 64'd0);
      checkOutput("d_arvld_hold", 64'(bus.arb_arvld), 64'd1);
      checkOutput("d_araddr_hold", 64'(bus.arb_araddr), 64'h3FF);
      checkOutput("d_arnum_hold", 64'(bus.arb_arnum), 64'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("d_arvld_accept", 64'(bus.arb_arvld), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("d_arvld_busy", 64'(bus.arb_arvld), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("d_done", 64'(bus.req_done), 64'b1000);
    nextCycle();

    // Reset asserted mid-BUSY, then rr_ptr must be back at 0
    $display("[TB] reset mid-busy");
    setReq(1, 10'h111, 8'd1, 12'h111);
    bus.req_arvld = 4'b0010;
    exp_grant_q.push_back(1);
    exp_done_q.push_back(1);
    runTxn(1, 10'h111, 8'd1, 64'h5555);
    setReq(2, 10'h222, 8'd5, 12'h222);
    bus.req_arvld = 4'b0100;
    exp_grant_q.push_back(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    bus.req_arvld = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 64'h99);
    checkOutput("e_rvld_busy", 64'(bus.req_rvld), 64'b0100);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 64'h99);
    checkOutput("e_rst_rvld", 64'(bus.req_rvld), 64'd0);
    checkOutput("e_rst_rrdy", 64'(bus.arb_rrdy), 64'd0);
    checkOutput("e_rst_arvld", 64'(bus.arb_arvld), 64'd0);
    checkOutput("e_rst_done", 64'(bus.req_done), 64'd0);
    nextCycle();
    rst = 1'b0;
    grant_open = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 64'h99);
    checkOutput("e_post_rvld", 64'(bus.req_rvld), 64'd0);
    checkOutput("e_post_rrdy", 64'(bus.arb_rrdy), 64'd0);
    checkOutput("e_post_araddr", 64'(bus.arb_araddr), 64'd0);
    checkOutput("e_post_sram", 64'(bus.arb_sram_addr), 64'd0);
    nextCycle();
    for (int i = 0; i < NREQ; i++) setReq(i, 10'(10'h300 + i), 8'd1, 12'(i));
    bus.req_arvld = 4'b1111;
    exp_grant_q.push_back(0);
    exp_done_q.push_back(0);
    runTxn(0, 10'h300, 8'd1, 64'hABCD);
    bus.req_arvld = '0;

`ifdef LSU_AXI_RD_ARB_WDOG_EN
    // Stall in BUSY without responses until the watchdog trips
    $display("[TB] watchdog");
    bus.req_arvld = 4'b0010;
    exp_grant_q.push_back(1);
    exp_done_q.push_back(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    bus.req_arvld = '0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("f_wdog_early", 64'(bus.wdog_err), 64'd0);
    nextCycle();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("f_wdog_set", 64'(bus.wdog_err), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 64'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("f_done", 64'(bus.req_done), 64'b0010);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("f_wdog_sticky", 64'(bus.wdog_err), 64'd1);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("f_wdog_cleared", 64'(bus.wdog_err), 64'd0);
    nextCycle();
`else
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 64'd0);
    checkOutput("wdog_tied_low", 64'(bus.wdog_err), 64'd0);
    nextCycle();
`endif

    checkOutput("grant_queue_empty", 64'(exp_grant_q.size()), 64'd0);
    checkOutput("done_queue_empty", 64'(exp_done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
